// File: rtl/equiv_stream_miter_if.sv
// equiv_stream_miter_if: the two result streams going into the miter and the
// comparison status coming back out. The producer side (bench or DUT pair)
// uses the master modport; the miter itself uses the slave modport.
interface equiv_stream_miter_if #(
  parameter int WIDTH = 91,
  parameter int CNT_W = 32
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic [1:0]       state;
  logic             mismatch;
  logic             overflow;
  logic             pending;
  logic [CNT_W-1:0] cmp_count;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] first_a;
  logic [WIDTH-1:0] first_b;
  logic [CNT_W-1:0] first_idx;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  state, mismatch, overflow, pending,
    input  cmp_count, err_count, first_a, first_b, first_idx
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output state, mismatch, overflow, pending,
    output cmp_count, err_count, first_a, first_b, first_idx
  );
endinterface

// File: rtl/equiv_stream_miter.sv
// equiv_stream_miter: sequential miter for equivalence regressions.
// Two skew FIFOs (A and B) absorb latency differences between the two designs
// under comparison; heads are popped together and compared one pair per cycle.
// The compare result is registered one cycle after the pop and folded into the
// counters, sticky flags, state and first-failure capture on the next edge.
// Optional build macro EQUIV_MITER_ASSERT_EN compiles in a checker that
// asserts equal popped heads and that no sample is ever dropped.
module equiv_stream_miter #(
  parameter int WIDTH        = 91,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  equiv_stream_miter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    FULL_CNT = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // FIFO storage and pointers (one extra pointer bit distinguishes full/empty)
  logic [WIDTH-1:0] a_mem_q [DEPTH];
  logic [WIDTH-1:0] a_mem_d [DEPTH];
  logic [WIDTH-1:0] b_mem_q [DEPTH];
  logic [WIDTH-1:0] b_mem_d [DEPTH];
  logic [PW-1:0]    a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PW-1:0]    b_wr_q, b_wr_d, b_rd_q, b_rd_d;

  // Compare stage: the pair popped last cycle, waiting to be scored
  logic             cmp_vld_q, cmp_vld_d;
  logic             cmp_ne_q, cmp_ne_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;

  // Status registers
  logic [1:0]       state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cmp_count_q, cmp_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] first_a_q, first_a_d;
  logic [WIDTH-1:0] first_b_q, first_b_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;

  // Per-cycle decode
  logic [PW-1:0]    a_fill_s, b_fill_s;
  logic             a_empty_s, b_empty_s, a_full_s, b_full_s;
  logic             fail_now_s, frozen_s, pop_s;
  logic             a_try_s, b_try_s, a_drop_s, b_drop_s, a_push_s, b_push_s;
  logic [WIDTH-1:0] a_head_s, b_head_s;

  assign a_head_s = a_mem_q[a_rd_q[AW-1:0]];
  assign b_head_s = b_mem_q[b_rd_q[AW-1:0]];

  // Occupancy, freeze, pop and push/drop decisions for this cycle.
  // A failing pair sitting in the compare stage already freezes a
  // STOP_ON_FAIL miter, so nothing behind it is popped or pushed.
  always_comb begin
    a_fill_s   = a_wr_q - a_rd_q;
    b_fill_s   = b_wr_q - b_rd_q;
    a_empty_s  = (a_fill_s == {PW{1'b0}});
    b_empty_s  = (b_fill_s == {PW{1'b0}});
    a_full_s   = (a_fill_s == FULL_CNT);
    b_full_s   = (b_fill_s == FULL_CNT);
    fail_now_s = cmp_vld_q & cmp_ne_q;
    frozen_s   = (state_q == ST_FAULT) |
                 (STOP_ON_FAIL & ((state_q == ST_MISMATCH) | fail_now_s));
    pop_s      = ~frozen_s & ~a_empty_s & ~b_empty_s;
    a_try_s    = bus.a_valid & ~frozen_s;
    b_try_s    = bus.b_valid & ~frozen_s;
    a_drop_s   = a_try_s & a_full_s & ~pop_s;
    b_drop_s   = b_try_s & b_full_s & ~pop_s;
    a_push_s   = a_try_s & ~a_drop_s;
    b_push_s   = b_try_s & ~b_drop_s;
  end

  // FIFO write/read pointer and storage updates; clear empties both sides.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    a_wr_d  = a_wr_q;
    a_rd_d  = a_rd_q;
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    if (clear) begin
      a_wr_d = {PW{1'b0}};
      a_rd_d = {PW{1'b0}};
      b_wr_d = {PW{1'b0}};
      b_rd_d = {PW{1'b0}};
    end else begin
      if (a_push_s) begin
        a_mem_d[a_wr_q[AW-1:0]] = bus.a_data;
        a_wr_d                  = a_wr_q + PW'(1);
      end else begin
        a_wr_d = a_wr_q;
      end
      if (b_push_s) begin
        b_mem_d[b_wr_q[AW-1:0]] = bus.b_data;
        b_wr_d                  = b_wr_q + PW'(1);
      end else begin
        b_wr_d = b_wr_q;
      end
      if (pop_s) begin
        a_rd_d = a_rd_q + PW'(1);
        b_rd_d = b_rd_q + PW'(1);
      end else begin
        a_rd_d = a_rd_q;
        b_rd_d = b_rd_q;
      end
    end
  end

  // Compare stage loading, scoring of the staged pair, and state transitions.
  always_comb begin
    cmp_vld_d   = cmp_vld_q;
    cmp_ne_d    = cmp_ne_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    state_d     = state_q;
    mismatch_d  = mismatch_q;
    overflow_d  = overflow_q;
    cmp_count_d = cmp_count_q;
    err_count_d = err_count_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_idx_d = first_idx_q;
    if (clear) begin
      cmp_vld_d   = 1'b0;
      cmp_ne_d    = 1'b0;
      cmp_a_d     = {WIDTH{1'b0}};
      cmp_b_d     = {WIDTH{1'b0}};
      state_d     = ST_RUN;
      mismatch_d  = 1'b0;
      overflow_d  = 1'b0;
      cmp_count_d = {CNT_W{1'b0}};
      err_count_d = {CNT_W{1'b0}};
      first_a_d   = {WIDTH{1'b0}};
      first_b_d   = {WIDTH{1'b0}};
      first_idx_d = {CNT_W{1'b0}};
    end else begin
      cmp_vld_d = pop_s;
      if (pop_s) begin
        cmp_ne_d = (a_head_s != b_head_s);
        cmp_a_d  = a_head_s;
        cmp_b_d  = b_head_s;
      end else begin
        cmp_ne_d = 1'b0;
      end

      if (cmp_vld_q) begin
        cmp_count_d = sat_inc(cmp_count_q);
        if (cmp_ne_q) begin
          err_count_d = sat_inc(err_count_q);
          mismatch_d  = 1'b1;
          if (!mismatch_q) begin
            first_a_d   = cmp_a_q;
            first_b_d   = cmp_b_q;
            first_idx_d = cmp_count_q;
          end else begin
            first_idx_d = first_idx_q;
          end
          if (state_q == ST_RUN) begin
            state_d = ST_MISMATCH;
          end else begin
            state_d = state_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
      end else begin
        cmp_count_d = cmp_count_q;
      end

      // A dropped sample breaks pairing for good: fault from any state.
      if (a_drop_s | b_drop_s) begin
        overflow_d = 1'b1;
        state_d    = ST_FAULT;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= {WIDTH{1'b0}};
        b_mem_q[i] <= {WIDTH{1'b0}};
      end
      a_wr_q      <= {PW{1'b0}};
      a_rd_q      <= {PW{1'b0}};
      b_wr_q      <= {PW{1'b0}};
      b_rd_q      <= {PW{1'b0}};
      cmp_vld_q   <= 1'b0;
      cmp_ne_q    <= 1'b0;
      cmp_a_q     <= {WIDTH{1'b0}};
      cmp_b_q     <= {WIDTH{1'b0}};
      state_q     <= ST_RUN;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      cmp_count_q <= {CNT_W{1'b0}};
      err_count_q <= {CNT_W{1'b0}};
      first_a_q   <= {WIDTH{1'b0}};
      first_b_q   <= {WIDTH{1'b0}};
      first_idx_q <= {CNT_W{1'b0}};
    end else begin
      a_mem_q     <= a_mem_d;
      b_mem_q     <= b_mem_d;
      a_wr_q      <= a_wr_d;
      a_rd_q      <= a_rd_d;
      b_wr_q      <= b_wr_d;
      b_rd_q      <= b_rd_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_ne_q    <= cmp_ne_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      state_q     <= state_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      cmp_count_q <= cmp_count_d;
      err_count_q <= err_count_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_idx_q <= first_idx_d;
    end
  end

  // pending follows the pointers directly so it tracks occupancy same-cycle.
  assign bus.pending   = ~a_empty_s | ~b_empty_s;
  assign bus.state     = state_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.overflow  = overflow_q;
  assign bus.cmp_count = cmp_count_q;
  assign bus.err_count = err_count_q;
  assign bus.first_a   = first_a_q;
  assign bus.first_b   = first_b_q;
  assign bus.first_idx = first_idx_q;

`ifdef EQUIV_MITER_ASSERT_EN
  equiv_stream_miter_chk #(.WIDTH(WIDTH)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop      (pop_s),
    .head_a   (a_head_s),
    .head_b   (b_head_s),
    .drop     (a_drop_s | b_drop_s)
  );
`else
  // Status outputs are the only failure report in this build.
`endif

endmodule

`ifdef EQUIV_MITER_ASSERT_EN
// Checker for assertion builds: equal heads on every pop, no dropped samples.
module equiv_stream_miter_chk #(
  parameter int WIDTH = 91
) (
  input logic             clk,
  input logic             rst_n,
  input logic             pop,
  input logic [WIDTH-1:0] head_a,
  input logic [WIDTH-1:0] head_b,
  input logic             drop
);
  // Heads leaving both FIFOs together must be bitwise equal.
  always @(posedge clk) begin
    if (rst_n && pop) begin
      heads_equal: assert (head_a == head_b);
    end
  end

  // A dropped sample is what raises overflow; it must never happen.
  always @(posedge clk) begin
    if (rst_n) begin
      no_overflow: assert (!drop);
    end
  end
endmodule
`else
// No checker module in the default build.
`endif
